// File: rtl/direction_pulser.sv
// Button front end for the room/sword game: synchronises and debounces four raw buttons,
// turns each accepted press into a single move pulse, flags chords and counts moves.
module direction_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_north,
    input  logic               btn_south,
    input  logic               btn_west,
    input  logic               btn_east,
    output logic               north,
    output logic               south,
    output logic               west,
    output logic               east,
    output logic               chord_err,
    output logic               busy,
    output logic [COUNT_W-1:0] move_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         raw;
    logic [3:0]         sync1;
    logic [3:0]         sync2;
    logic [3:0]         stable;
    logic [CNT_W-1:0]   cnt [4];
    logic [3:0]         move_next;
    logic               chord_next;
    logic               one_hot;

    // Bit order throughout is {north, south, west, east}.
    assign raw = {btn_north, btn_south, btn_west, btn_east};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level only changes after DEBOUNCE_CYCLES consecutive edges of disagreement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign one_hot = (stable != 4'b0000) && ((stable & (stable - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (stable != 4'b0000) next_state = HELD;
            HELD:    if (stable == 4'b0000) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        move_next  = 4'b0000;
        chord_next = 1'b0;
        if (state == IDLE && stable != 4'b0000) begin
            if (one_hot) begin
                move_next = stable;
            end else begin
                chord_next = 1'b1;
            end
        end
    end

    // Pulses are registered so the game FSM sees glitch-free single-cycle strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            north      <= 1'b0;
            south      <= 1'b0;
            west       <= 1'b0;
            east       <= 1'b0;
            chord_err  <= 1'b0;
            move_count <= '0;
        end else begin
            {north, south, west, east} <= move_next;
            chord_err                  <= chord_next;
            if (move_next != 4'b0000 && move_count != {COUNT_W{1'b1}}) begin
                move_count <= move_count + 1'b1;
            end
        end
    end

    assign busy = (state == HELD);

endmodule
